// File: rtl/dmem_latency.sv
// Word-organised data memory responder with byte-masked writes and a fixed response latency.
// Optional range checking (op_data_err port) is built when DMEM_RANGE_CHECK_EN is defined.
module dmem_latency #(
  parameter int SIZE_IN_BYTES = 64,
  parameter int LATENCY       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_dmem
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        op_data_err
`endif
);

  localparam int WORDS = SIZE_IN_BYTES / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  logic [31:0] mem [0:WORDS-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        oob_q, oob_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          req;
  logic          commit;
  logic          in_oob;
  logic [AW-1:0] c_idx;
  logic [3:0]    c_mask;
  logic [31:0]   c_wdata;
  logic          c_wr;
  logic          c_oob;
  logic          wr_en;
  logic          unused_addr_bits;

  assign req = ip_data_rd | ip_data_wr;
  assign unused_addr_bits = ^{ip_data_addr[31:AW+2], ip_data_addr[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  assign in_oob = |ip_data_addr[31:AW+2];
`else
  assign in_oob = 1'b0;
`endif

  // With LATENCY=1 the commit happens on the accepting edge, so the
  // live inputs (not the latched copy) must feed the commit path.
  always_comb begin
    if (state_q == S_IDLE) begin
      c_idx   = ip_data_addr[AW+1:2];
      c_mask  = ip_data_mask;
      c_wdata = ip_data_from_proc;
      c_wr    = ip_data_wr;
      c_oob   = in_oob;
    end else begin
      c_idx   = idx_q;
      c_mask  = mask_q;
      c_wdata = wdata_q;
      c_wr    = wr_q;
      c_oob   = oob_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oob_d   = oob_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = ip_data_addr[AW+1:2];
          oob_d   = in_oob;
          mask_d  = ip_data_mask;
          wdata_d = ip_data_from_proc;
          wr_d    = ip_data_wr;
          cnt_d   = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is the pre-write word, so a combined rd+wr returns old contents.
  always_comb begin
    valid_d = commit;
    err_d   = commit & c_oob;
    rdata_d = rdata_q;
    if (commit) rdata_d = c_oob ? 32'h0 : mem[c_idx];
  end

  assign wr_en = commit & c_wr & ~c_oob & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      oob_q   <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oob_q   <= oob_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (c_mask[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  assign op_data_valid     = valid_q;
  assign op_data_from_dmem = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign op_data_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
